// File: rtl/cplx_div_seq_if.sv
// Handshake and operand/result bundle for cplx_div_seq.
//   master: drives in_valid, a_r/a_i/b_r/b_i and out_ready; observes in_ready,
//           out_valid, y_r/y_i, div_zero and ovf.
//   slave : the divider side of the same signals.
interface cplx_div_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] a_r;
  logic signed [DATA_WIDTH-1:0] a_i;
  logic signed [DATA_WIDTH-1:0] b_r;
  logic signed [DATA_WIDTH-1:0] b_i;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] y_r;
  logic signed [DATA_WIDTH-1:0] y_i;
  logic                         div_zero;
  logic                         ovf;

  modport master (
    output in_valid, a_r, a_i, b_r, b_i, out_ready,
    input  in_ready, out_valid, y_r, y_i, div_zero, ovf
  );

  modport slave (
    input  in_valid, a_r, a_i, b_r, b_i, out_ready,
    output in_ready, out_valid, y_r, y_i, div_zero, ovf
  );
endinterface

// File: rtl/cplx_div_seq.sv
// Sequential complex divider y = a / b = a*conj(b) / |b|^2.
// One multiply cycle, then a 1-bit-per-cycle restoring division of |num_r| and
// |num_i| in parallel; quotients truncate toward zero.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - cplx_div_seq_if.slave: in_valid/in_ready + a_r,a_i,b_r,b_i in;
//          out_valid/out_ready + y_r,y_i,div_zero,ovf out
// Build option: define CDIV_SAT_EN to clamp out-of-range quotient components;
// otherwise the low DATA_WIDTH bits are output (wrap). ovf is the same in both.
module cplx_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  cplx_div_seq_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int W2 = 2 * DW + 1;
  localparam int CW = $clog2(W2);
  localparam logic [W2-1:0] LIM_POS = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic [W2-1:0] LIM_NEG = LIM_POS + W2'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] a_r_q, a_r_d, a_i_q, a_i_d, b_r_q, b_r_d, b_i_q, b_i_d;
  logic [W2-1:0]        dvd_r_q, dvd_r_d, dvd_i_q, dvd_i_d;
  logic [W2-1:0]        rem_r_q, rem_r_d, rem_i_q, rem_i_d;
  logic [W2-1:0]        den_q, den_d;
  logic                 neg_r_q, neg_r_d, neg_i_q, neg_i_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] y_r_q, y_r_d, y_i_q, y_i_d;
  logic                 div_zero_q, div_zero_d, ovf_q, ovf_d;

  logic signed [W2-1:0] ar_x, ai_x, br_x, bi_x, num_r, num_i, den_s;
  logic [2*W2-1:0]      step_r, step_i;
  logic [DW:0]          fin_r, fin_i;

  // One restoring step: shift the dividend MSB into the partial remainder,
  // subtract if it fits, and shift the quotient bit into the dividend LSB.
  // After W2 steps the dividend register holds the magnitude quotient.
  // The remainder never exceeds den-1 < 2^(W2-2), so its top bit is always 0.
  function automatic logic [2*W2-1:0] div_step(input logic [W2-1:0] rem,
                                               input logic [W2-1:0] dvd,
                                               input logic [W2-1:0] den);
    logic [W2-1:0] sh;
    logic          qb;
    sh = W2'({rem, dvd[W2-1]});
    qb = (sh >= den);
    return {(qb ? sh - den : sh), dvd[W2-2:0], qb};
  endfunction

  // Apply the sign to a magnitude quotient; returns {ovf, y}.
  function automatic logic [DW:0] finalize(input logic [W2-1:0] mag, input logic neg);
    logic          over;
    logic [DW-1:0] y;
    over = neg ? (mag > LIM_NEG) : (mag > LIM_POS);
`ifdef CDIV_SAT_EN
    if (over) y = neg ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    else      y = neg ? -mag[DW-1:0] : mag[DW-1:0];
`else
    y = neg ? -mag[DW-1:0] : mag[DW-1:0];
`endif
    return {over, y};
  endfunction

  always_comb begin
    ar_x  = {{(DW + 1){a_r_q[DW-1]}}, a_r_q};
    ai_x  = {{(DW + 1){a_i_q[DW-1]}}, a_i_q};
    br_x  = {{(DW + 1){b_r_q[DW-1]}}, b_r_q};
    bi_x  = {{(DW + 1){b_i_q[DW-1]}}, b_i_q};
    num_r = ar_x * br_x + ai_x * bi_x;
    num_i = ai_x * br_x - ar_x * bi_x;
    den_s = br_x * br_x + bi_x * bi_x;
    step_r = div_step(rem_r_q, dvd_r_q, den_q);
    step_i = div_step(rem_i_q, dvd_i_q, den_q);
    fin_r  = finalize(step_r[W2-1:0], neg_r_q);
    fin_i  = finalize(step_i[W2-1:0], neg_i_q);
  end

  always_comb begin
    state_d    = state_q;
    a_r_d      = a_r_q;
    a_i_d      = a_i_q;
    b_r_d      = b_r_q;
    b_i_d      = b_i_q;
    dvd_r_d    = dvd_r_q;
    dvd_i_d    = dvd_i_q;
    rem_r_d    = rem_r_q;
    rem_i_d    = rem_i_q;
    den_d      = den_q;
    neg_r_d    = neg_r_q;
    neg_i_d    = neg_i_q;
    cnt_d      = cnt_q;
    y_r_d      = y_r_q;
    y_i_d      = y_i_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_r_d   = bus.a_r;
          a_i_d   = bus.a_i;
          b_r_d   = bus.b_r;
          b_i_d   = bus.b_i;
          state_d = MUL;
        end
      end
      MUL: begin
        dvd_r_d = num_r[W2-1] ? -num_r : num_r;
        dvd_i_d = num_i[W2-1] ? -num_i : num_i;
        neg_r_d = num_r[W2-1];
        neg_i_d = num_i[W2-1];
        den_d   = den_s;
        rem_r_d = '0;
        rem_i_d = '0;
        cnt_d   = '0;
        if (den_s == '0) begin
          y_r_d      = '0;
          y_i_d      = '0;
          div_zero_d = 1'b1;
          ovf_d      = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        {rem_r_d, dvd_r_d} = step_r;
        {rem_i_d, dvd_i_d} = step_i;
        cnt_d = cnt_q + CW'(1);
        // Outputs are registered on the last step so they only move on DONE entry.
        if (cnt_q == CW'(W2 - 1)) begin
          y_r_d      = fin_r[DW-1:0];
          y_i_d      = fin_i[DW-1:0];
          ovf_d      = fin_r[DW] | fin_i[DW];
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_r_q      <= '0;
      a_i_q      <= '0;
      b_r_q      <= '0;
      b_i_q      <= '0;
      dvd_r_q    <= '0;
      dvd_i_q    <= '0;
      rem_r_q    <= '0;
      rem_i_q    <= '0;
      den_q      <= '0;
      neg_r_q    <= 1'b0;
      neg_i_q    <= 1'b0;
      cnt_q      <= '0;
      y_r_q      <= '0;
      y_i_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_r_q      <= a_r_d;
      a_i_q      <= a_i_d;
      b_r_q      <= b_r_d;
      b_i_q      <= b_i_d;
      dvd_r_q    <= dvd_r_d;
      dvd_i_q    <= dvd_i_d;
      rem_r_q    <= rem_r_d;
      rem_i_q    <= rem_i_d;
      den_q      <= den_d;
      neg_r_q    <= neg_r_d;
      neg_i_q    <= neg_i_d;
      cnt_q      <= cnt_d;
      y_r_q      <= y_r_d;
      y_i_q      <= y_i_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y_r       = y_r_q;
  assign bus.y_i       = y_i_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cplx_div_seq.sv
module tb_cplx_div_seq;
  localparam int DW = 16;

  typedef struct {
    logic signed [DW-1:0] yr;
    logic signed [DW-1:0] yi;
    logic                 dz;
    logic                 ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  cplx_div_seq_if #(.DATA_WIDTH(DW)) bus ();

  cplx_div_seq #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical definition.
  function automatic logic signed [DW-1:0] fit(input longint q);
    longint lo, hi;
    logic [63:0] qb;
    lo = -(longint'(1) << (DW - 1));
    hi = (longint'(1) << (DW - 1)) - 1;
    qb = q;
`ifdef CDIV_SAT_EN
    if (q > hi) return DW'(hi);
    if (q < lo) return DW'(lo);
`endif
    return qb[DW-1:0];
  endfunction

  function automatic exp_t model(input int ar, input int ai, input int br, input int bi);
    exp_t   e;
    longint nr, ni, den, qr, qi, lo, hi;
    lo  = -(longint'(1) << (DW - 1));
    hi  = (longint'(1) << (DW - 1)) - 1;
    nr  = longint'(ar) * br + longint'(ai) * bi;
    ni  = longint'(ai) * br - longint'(ar) * bi;
    den = longint'(br) * br + longint'(bi) * bi;
    if (den == 0) begin
      e.yr = '0; e.yi = '0; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      qr   = nr / den;
      qi   = ni / den;
      e.yr = fit(qr);
      e.yi = fit(qi);
      e.dz = 1'b0;
      e.ov = (qr > hi) || (qr < lo) || (qi > hi) || (qi < lo);
    end
    return e;
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("y_r", longint'(bus.y_r), longint'(e.yr));
          check("y_i", longint'(bus.y_i), longint'(e.yi));
          check("div_zero", longint'(bus.div_zero), longint'(e.dz));
          check("ovf", longint'(bus.ovf), longint'(e.ov));
        end
      end
    end
  end

  task automatic junk_inputs();
    bus.a_r = DW'($urandom);
    bus.a_i = DW'($urandom);
    bus.b_r = DW'($urandom);
    bus.b_i = DW'($urandom);
  endtask

  // Present an operand set and return #1 after its acceptance edge.
  task automatic issue(input int ar, input int ai, input int br, input int bi);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("in_ready_timeout", 0, 1);
    bus.a_r = DW'(ar);
    bus.a_i = DW'(ai);
    bus.b_r = DW'(br);
    bus.b_i = DW'(bi);
    bus.in_valid = 1'b1;
    sb.push_back(model(ar, ai, br, bi));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    junk_inputs();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input int ar, input int ai,
                        input int br, input int bi);
    int n;
    int lat;
    lat = (br == 0 && bi == 0) ? 1 : 2 * DW + 2;
    issue(ar, ai, br, bi);
    wait_valid(n);
    check(name, n, lat);
    accept();
  endtask

  initial begin
    int n;
    int ar, ai, br, bi;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    junk_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_y_r", longint'(bus.y_r), 0);
    check("rst_y_i", longint'(bus.y_i), 0);
    check("rst_div_zero", longint'(bus.div_zero), 0);
    check("rst_ovf", longint'(bus.ovf), 0);

    run_op("lat_basic", 100, 50, 3, 4);
    run_op("lat_pos_trunc", 7, 0, 2, 0);
    run_op("lat_neg_trunc", -7, 0, 2, 0);
    run_op("lat_div_zero", 1234, -5, 0, 0);
    run_op("lat_ovf", -32768, 0, -1, 0);

    // Hold the result with out_ready low while offering a competing input.
    issue(100, 50, 3, 4);
    wait_valid(n);
    check("lat_hold", n, 2 * DW + 2);
    bus.in_valid = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_out_valid", longint'(bus.out_valid), 1);
      check("hold_in_ready", longint'(bus.in_ready), 0);
      check("hold_y_r", longint'(bus.y_r), 20);
      check("hold_y_i", longint'(bus.y_i), -10);
    end
    bus.in_valid = 1'b0;
    accept();
    check("pulse_out_valid", longint'(bus.out_valid), 0);
    check("pulse_in_ready", longint'(bus.in_ready), 1);
    run_op("lat_b2b", 10, 33, 45, -24);

    // Reset in the middle of the divide: the in-flight op is discarded.
    issue(100, 50, 3, 4);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", longint'(bus.in_ready), 1);
    n = 0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("midrst_no_valid", n, 0);
    run_op("lat_after_rst", 100, 50, 3, 4);

    // Random operands, with occasional zero divisors and extreme values.
    for (int unsigned k = 0; k < 40; k++) begin
      ar = int'($signed(DW'($urandom)));
      ai = int'($signed(DW'($urandom)));
      br = int'($signed(DW'($urandom)));
      bi = int'($signed(DW'($urandom)));
      case ($urandom_range(0, 5))
        0: begin br = 0; bi = 0; end
        1: begin br = $urandom_range(0, 3) - 1; bi = 0; end
        2: begin ar = -32768; ai = 32767; end
        3: begin br = $urandom_range(0, 15) - 8; bi = $urandom_range(0, 15) - 8; end
        default: ;
      endcase
      issue(ar, ai, br, bi);
      wait_valid(n);
      check("lat_random", n, (br == 0 && bi == 0) ? 1 : 2 * DW + 2);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      accept();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
